fc_window_data_ram: RTL and testbench

Parametrised sliding-window data buffer for the fully-connected layers; next generation of the fixed 16×16-bit, 5-tap FC data RAM. Previous-layer activations stream in through a valid/ready port with an auto-incrementing write pointer. On Start, the block sweeps the stored vector and emits one `Taps`-wide window per accepted beat, advancing by a programmable stride. Taps past the current fill level read as zero. The block sits between the previous layer's output stage and the MAC array of the next FC layer.

---
 rtl/fc_window_data_ram.sv | 163 ++++++++++++++++
 tb/tb_fc_window_data_ram.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/fc_window_data_ram.sv
// Sliding-window activation buffer for an FC layer: linear fill through a valid/ready port,
// then a strided sweep that presents Taps-wide zero-padded windows to the MAC array.
module fc_window_data_ram #(
    parameter int unsigned Bit_width  = 16,
    parameter int unsigned RAM_Depth  = 16,
    parameter int unsigned Taps       = 5,
    parameter int unsigned Addr_width = $clog2(RAM_Depth)
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          Clear,
    input  logic                          In_Valid,
    input  logic [Bit_width-1:0]          data_in,
    output logic                          In_Ready,
    output logic [Addr_width:0]           Fill_Count,
    output logic                          Full,
    input  logic                          Start,
    input  logic [Addr_width-1:0]         Stride,
    output logic                          Busy,
    input  logic                          Out_Ready,
    output logic                          Out_Valid,
    output logic                          Out_Last,
    output logic [Taps*Bit_width-1:0]     data_out
);

    localparam int unsigned CW = Addr_width + 1;
    localparam int unsigned XW = Addr_width + 2;

    typedef enum logic {
        IDLE,
        SWEEP
    } state_t;

    state_t                  state;
    state_t                  state_next;

    logic [Bit_width-1:0]    ram [RAM_Depth];
    logic [Addr_width-1:0]   wr_ptr;
    logic [CW-1:0]           rd_ptr;
    logic [Addr_width-1:0]   stride_q;

    logic                    wr_en;
    logic [CW-1:0]           fill_next;
    logic [Addr_width-1:0]   stride_eff;
    logic                    start_ok;
    logic                    adv;
    logic                    finish;
    logic [CW-1:0]           base_sel;
    logic [Addr_width-1:0]   stride_sel;
    logic                    next_last;
    logic [Taps*Bit_width-1:0] win;

    assign Full       = (Fill_Count == CW'(RAM_Depth));
    assign In_Ready   = (state == IDLE) && !Full;
    assign Busy       = (state == SWEEP);
    assign wr_en      = In_Valid && In_Ready && !Clear;
    assign fill_next  = Fill_Count + CW'(wr_en);
    assign stride_eff = (Stride == '0) ? Addr_width'(1) : Stride;

    // State register
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and sweep control
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        adv        = 1'b0;
        finish     = 1'b0;
        case (state)
            IDLE: begin
                if (Start && (fill_next != '0)) begin
                    start_ok   = 1'b1;
                    state_next = SWEEP;
                end
            end
            SWEEP: begin
                if (Out_Ready) begin
                    if (Out_Last) begin
                        finish     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (Clear) begin
            state_next = IDLE;
            start_ok   = 1'b0;
            adv        = 1'b0;
            finish     = 1'b0;
        end
    end

    assign base_sel   = start_ok ? '0 : rd_ptr;
    assign stride_sel = start_ok ? stride_eff : stride_q;
    assign next_last  = (XW'(base_sel) + XW'(stride_sel)) >= XW'(fill_next);

    // Window taps; a write landing on the Start edge is bypassed into the first window
    for (genvar i = 0; i < Taps; i++) begin : g_tap
        logic [XW-1:0]         idx;
        logic [Addr_width-1:0] addr;
        assign idx  = XW'(base_sel) + XW'(i);
        assign addr = idx[Addr_width-1:0];
        assign win[i*Bit_width +: Bit_width] =
            (idx < XW'(fill_next)) ? ((wr_en && (addr == wr_ptr)) ? data_in : ram[addr])
                                   : '0;
    end

    // Storage array is not reset; Fill_Count masks stale contents
    always_ff @(negedge CLK) begin
        if (wr_en) begin
            ram[wr_ptr] <= data_in;
        end
    end

    // Pointers, counters and output window registers
    always_ff @(negedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr     <= '0;
            Fill_Count <= '0;
            rd_ptr     <= '0;
            stride_q   <= Addr_width'(1);
            Out_Valid  <= 1'b0;
            Out_Last   <= 1'b0;
            data_out   <= '0;
        end else if (Clear) begin
            wr_ptr     <= '0;
            Fill_Count <= '0;
            rd_ptr     <= '0;
            Out_Valid  <= 1'b0;
            Out_Last   <= 1'b0;
            data_out   <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr     <= wr_ptr + Addr_width'(1);
                Fill_Count <= fill_next;
            end
            if (start_ok) begin
                stride_q  <= stride_eff;
                rd_ptr    <= CW'(stride_eff);
                data_out  <= win;
                Out_Valid <= 1'b1;
                Out_Last  <= next_last;
            end else if (adv) begin
                rd_ptr   <= rd_ptr + CW'(stride_q);
                data_out <= win;
                Out_Last <= next_last;
            end else if (finish) begin
                Out_Valid <= 1'b0;
                Out_Last  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fc_window_data_ram.sv
// Directed vector bench for fc_window_data_ram: cycle table plus hand sequences for
// start-with-write and asynchronous reset during a sweep.
module tb_fc_window_data_ram;

    logic        CLK;
    logic        RST_N;
    logic        Clear;
    logic        In_Valid;
    logic [15:0] data_in;
    logic        In_Ready;
    logic [4:0]  Fill_Count;
    logic        Full;
    logic        Start;
    logic [3:0]  Stride;
    logic        Busy;
    logic        Out_Ready;
    logic        Out_Valid;
    logic        Out_Last;
    logic [79:0] data_out;

    int checks = 0;
    int errors = 0;

    fc_window_data_ram dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .Clear      (Clear),
        .In_Valid   (In_Valid),
        .data_in    (data_in),
        .In_Ready   (In_Ready),
        .Fill_Count (Fill_Count),
        .Full       (Full),
        .Start      (Start),
        .Stride     (Stride),
        .Busy       (Busy),
        .Out_Ready  (Out_Ready),
        .Out_Valid  (Out_Valid),
        .Out_Last   (Out_Last),
        .data_out   (data_out)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    typedef struct {
        logic        iv;
        logic [15:0] d;
        logic        st;
        logic [3:0]  stride;
        logic        ordy;
        logic        clr;
        logic [4:0]  fill;
        logic        full;
        logic        ir;
        logic        busy;
        logic        ov;
        logic        last;
        logic [79:0] dout;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(logic iv, logic [15:0] d, logic st, logic [3:0] stride,
                                logic ordy, logic clr, logic [4:0] fill, logic full,
                                logic ir, logic busy, logic ov, logic last, logic [79:0] dout);
        vec_t v;
        v.iv = iv; v.d = d; v.st = st; v.stride = stride; v.ordy = ordy; v.clr = clr;
        v.fill = fill; v.full = full; v.ir = ir; v.busy = busy; v.ov = ov; v.last = last;
        v.dout = dout;
        return v;
    endfunction

    // Expected window when stored word k holds v0+k
    function automatic logic [79:0] ew(int base, int fill, int v0);
        logic [79:0] r;
        r = '0;
        for (int i = 0; i < 5; i++)
            if (base + i < fill) r[i*16 +: 16] = 16'(v0 + base + i);
        return r;
    endfunction

    function automatic logic [79:0] pk(int a, int b, int c, int d, int e);
        return {16'(e), 16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(string name, logic [79:0] act, logic [79:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
        #1;
    endtask

    task automatic set_in(logic iv, logic [15:0] d, logic st, logic [3:0] stride,
                          logic ordy, logic clr);
        In_Valid = iv; data_in = d; Start = st; Stride = stride;
        Out_Ready = ordy; Clear = clr;
    endtask

    initial begin
        RST_N = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);

        // Fill phase, start ignored while empty, stride-1 sweep over a full RAM
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0, '0));
        for (int i = 0; i < 16; i++)
            vq.push_back(mk(1, 16'(i + 1), 0, 0, 0, 0, 5'(i + 1), i == 15, i != 15, 0, 0, 0, '0));
        vq.push_back(mk(1, 99, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0, '0));
        vq.push_back(mk(0, 0, 1, 1, 1, 0, 16, 1, 0, 1, 1, 0, pk(1, 2, 3, 4, 5)));
        for (int b = 1; b < 16; b++) begin
            logic [79:0] w;
            w = ew(b, 16, 1);
            if (b == 12) w = pk(13, 14, 15, 16, 0);
            if (b == 15) w = pk(16, 0, 0, 0, 0);
            vq.push_back(mk(0, 0, 0, 0, 1, 0, 16, 1, 0, 1, 1, b == 15, w));
        end
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 16, 1, 0, 0, 0, 0, pk(16, 0, 0, 0, 0)));
        vq.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, '0));
        // Stride 5 over 7 words with 3 edges of backpressure on the first window
        for (int i = 0; i < 7; i++)
            vq.push_back(mk(1, 16'(10 + i), 0, 0, 0, 0, 5'(i + 1), 0, 1, 0, 0, 0, '0));
        vq.push_back(mk(0, 0, 1, 5, 0, 0, 7, 0, 0, 1, 1, 0, pk(10, 11, 12, 13, 14)));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 0, 1, 1, 0, pk(10, 11, 12, 13, 14)));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 1, 1, pk(15, 16, 0, 0, 0)));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 1, 0, 0, 0, pk(15, 16, 0, 0, 0)));
        // Stride 0 acts as 1, then Clear aborts the sweep
        vq.push_back(mk(0, 0, 1, 0, 0, 0, 7, 0, 0, 1, 1, 0, pk(10, 11, 12, 13, 14)));
        vq.push_back(mk(0, 0, 0, 0, 1, 0, 7, 0, 0, 1, 1, 0, pk(11, 12, 13, 14, 15)));
        vq.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, '0));
        for (int i = 0; i < 3; i++)
            vq.push_back(mk(1, 16'(i + 1), 0, 0, 0, 0, 5'(i + 1), 0, 1, 0, 0, 0, '0));

        // Reset state
        tick();
        chk("rst_fill", 80'(Fill_Count), 0);
        chk("rst_ov", 80'(Out_Valid), 0);
        chk("rst_dout", data_out, 0);
        chk("rst_busy", 80'(Busy), 0);
        @(posedge CLK);
        RST_N = 1'b1;
        tick();
        chk("rst_ir", 80'(In_Ready), 1);

        foreach (vq[k]) begin
            set_in(vq[k].iv, vq[k].d, vq[k].st, vq[k].stride, vq[k].ordy, vq[k].clr);
            tick();
            chk($sformatf("v%0d_fill", k), 80'(Fill_Count), 80'(vq[k].fill));
            chk($sformatf("v%0d_full", k), 80'(Full), 80'(vq[k].full));
            chk($sformatf("v%0d_ir", k), 80'(In_Ready), 80'(vq[k].ir));
            chk($sformatf("v%0d_busy", k), 80'(Busy), 80'(vq[k].busy));
            chk($sformatf("v%0d_ov", k), 80'(Out_Valid), 80'(vq[k].ov));
            chk($sformatf("v%0d_last", k), 80'(Out_Last), 80'(vq[k].last));
            chk($sformatf("v%0d_dout", k), data_out, vq[k].dout);
        end

        // Start and write on the same edge: word 4 joins the sweep
        set_in(1, 4, 1, 2, 1, 0);
        tick();
        chk("sw_fill", 80'(Fill_Count), 4);
        chk("sw_win0", data_out, pk(1, 2, 3, 4, 0));
        chk("sw_last0", 80'(Out_Last), 0);
        chk("sw_ov0", 80'(Out_Valid), 1);
        set_in(0, 0, 0, 2, 1, 0);
        tick();
        chk("sw_win1", data_out, pk(3, 4, 0, 0, 0));
        chk("sw_last1", 80'(Out_Last), 1);
        tick();
        chk("sw_done_ov", 80'(Out_Valid), 0);
        chk("sw_done_busy", 80'(Busy), 0);
        chk("sw_done_ir", 80'(In_Ready), 1);

        // Asynchronous reset mid-cycle during a sweep
        set_in(0, 0, 1, 1, 0, 0);
        tick();
        chk("ar_ov_pre", 80'(Out_Valid), 1);
        set_in(0, 0, 0, 1, 0, 0);
        @(posedge CLK);
        RST_N = 1'b0;
        #1;
        chk("ar_ov", 80'(Out_Valid), 0);
        chk("ar_fill", 80'(Fill_Count), 0);
        chk("ar_busy", 80'(Busy), 0);
        chk("ar_dout", data_out, 0);
        chk("ar_last", 80'(Out_Last), 0);
        @(posedge CLK);
        RST_N = 1'b1;
        tick();
        chk("ar_ir", 80'(In_Ready), 1);
        chk("ar_fill_post", 80'(Fill_Count), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
